// File: rtl/turn_controller.sv
// Blackjack round sequencer: initial deal, player hit/stand turns, dealer draw-to-stand, outcome resolution.
// Latency: one cycle per state; dealReq rises the cycle after a deal state is entered and drops the cycle after dealDone.
// Backpressure: a deal request is held until dealDone; a button press is acted on only once ready is released.
package turn_controller_pkg;
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        HIT   = 2'd1,
        STAND = 2'd2
    } gameCommand;
endpackage

module turn_controller #(
    parameter int DEALER_STAND = 17,
    parameter int BUST_LIMIT   = 21
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            ready,
    input  turn_controller_pkg::gameCommand command,
    input  logic [4:0]                      playerTotal,
    input  logic [4:0]                      dealerTotal,
    input  logic                            dealDone,
    output logic                            turnIndicator,
    output logic                            dealReq,
    output logic                            dealTarget,
    output logic                            roundDone,
    output logic [1:0]                      result
);
    import turn_controller_pkg::*;

    typedef enum logic [3:0] {
        IDLE,
        INIT_DEAL,
        PLAYER_WAIT,
        PLAYER_RELEASE,
        PLAYER_DEAL,
        PLAYER_CHECK,
        DEALER_CHECK,
        DEALER_DEAL,
        RESOLVE,
        DONE
    } state_t;

    localparam logic [4:0] STAND_LIM = 5'(DEALER_STAND);
    localparam logic [4:0] BUST_LIM  = 5'(BUST_LIMIT);

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_PLAYER = 2'd1;
    localparam logic [1:0] RES_DEALER = 2'd2;
    localparam logic [1:0] RES_PUSH   = 2'd3;

    state_t     state;
    logic [1:0] deal_cnt;
    logic       hit_pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deal_cnt      <= 2'd0;
            hit_pending   <= 1'b0;
            turnIndicator <= 1'b0;
            dealReq       <= 1'b0;
            dealTarget    <= 1'b0;
            roundDone     <= 1'b0;
            result        <= RES_NONE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result    <= RES_NONE;
                        roundDone <= 1'b0;
                        deal_cnt  <= 2'd0;
                        state     <= INIT_DEAL;
                    end
                end
                // Odd deal slots go to the dealer: player, dealer, player, dealer.
                INIT_DEAL: begin
                    if (!dealReq) begin
                        dealReq    <= 1'b1;
                        dealTarget <= deal_cnt[0];
                    end else if (dealDone) begin
                        dealReq  <= 1'b0;
                        deal_cnt <= deal_cnt + 2'd1;
                        if (deal_cnt == 2'd3) begin
                            state <= PLAYER_CHECK;
                        end
                    end
                end
                PLAYER_CHECK: begin
                    if (playerTotal > BUST_LIM) begin
                        state <= RESOLVE;
                    end else begin
                        turnIndicator <= 1'b1;
                        state         <= PLAYER_WAIT;
                    end
                end
                PLAYER_WAIT: begin
                    if (ready && (command == HIT || command == STAND)) begin
                        hit_pending   <= (command == HIT);
                        turnIndicator <= 1'b0;
                        state         <= PLAYER_RELEASE;
                    end
                end
                // Waiting for release makes a held button count as a single press.
                PLAYER_RELEASE: begin
                    if (!ready) begin
                        state <= hit_pending ? PLAYER_DEAL : DEALER_CHECK;
                    end
                end
                PLAYER_DEAL: begin
                    if (!dealReq) begin
                        dealReq    <= 1'b1;
                        dealTarget <= 1'b0;
                    end else if (dealDone) begin
                        dealReq <= 1'b0;
                        state   <= PLAYER_CHECK;
                    end
                end
                DEALER_CHECK: begin
                    state <= (dealerTotal < STAND_LIM) ? DEALER_DEAL : RESOLVE;
                end
                DEALER_DEAL: begin
                    if (!dealReq) begin
                        dealReq    <= 1'b1;
                        dealTarget <= 1'b1;
                    end else if (dealDone) begin
                        dealReq <= 1'b0;
                        state   <= DEALER_CHECK;
                    end
                end
                RESOLVE: begin
                    if (playerTotal > BUST_LIM) begin
                        result <= RES_DEALER;
                    end else if (dealerTotal > BUST_LIM) begin
                        result <= RES_PLAYER;
                    end else if (playerTotal > dealerTotal) begin
                        result <= RES_PLAYER;
                    end else if (dealerTotal > playerTotal) begin
                        result <= RES_DEALER;
                    end else begin
                        result <= RES_PUSH;
                    end
                    roundDone <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: deal order, bust, dealer draw, held button, push, dealer bust, async reset.
module tb_turn_controller;
    import turn_controller_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ready;
    gameCommand command;
    logic [4:0] playerTotal;
    logic [4:0] dealerTotal;
    logic       dealDone;
    logic       turnIndicator;
    logic       dealReq;
    logic       dealTarget;
    logic       roundDone;
    logic [1:0] result;

    int errors = 0;
    int checks = 0;
    int player_rises = 0;
    int dealer_rises = 0;
    logic req_q = 1'b0;

    turn_controller #(.DEALER_STAND(17), .BUST_LIMIT(21)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ready(ready),
        .command(command),
        .playerTotal(playerTotal),
        .dealerTotal(dealerTotal),
        .dealDone(dealDone),
        .turnIndicator(turnIndicator),
        .dealReq(dealReq),
        .dealTarget(dealTarget),
        .roundDone(roundDone),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count each new deal request per target, sampled away from the active edge.
    always @(negedge clk) begin
        if (dealReq && !req_q) begin
            if (dealTarget) dealer_rises++;
            else            player_rises++;
        end
        req_q = dealReq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && dealReq !== 1'b1; i++) tick();
        check({tag, "_req"}, 8'(dealReq), 8'd1);
    endtask

    // Answer one deal request, updating the hand totals alongside dealDone as the datapath would.
    task automatic serve_deal(input string tag, input logic tgt, input logic [4:0] ptot, input logic [4:0] dtot);
        wait_req(tag);
        check({tag, "_tgt"}, 8'(dealTarget), 8'(tgt));
        dealDone    = 1'b1;
        playerTotal = ptot;
        dealerTotal = dtot;
        tick();
        dealDone = 1'b0;
        check({tag, "_drop"}, 8'(dealReq), 8'd0);
    endtask

    task automatic press(input gameCommand cmd);
        ready   = 1'b1;
        command = cmd;
        tick();
        ready   = 1'b0;
        command = NONE;
        tick();
    endtask

    task automatic start_round(input string tag, input logic [4:0] p1, input logic [4:0] d1,
                               input logic [4:0] p2, input logic [4:0] d2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_res_clr"}, 8'(result), 8'd0);
        check({tag, "_done_clr"}, 8'(roundDone), 8'd0);
        serve_deal({tag, "_d1"}, 1'b0, p1, 5'd0);
        serve_deal({tag, "_d2"}, 1'b1, p1, d1);
        serve_deal({tag, "_d3"}, 1'b0, p2, d1);
        serve_deal({tag, "_d4"}, 1'b1, p2, d2);
        tick();
        check({tag, "_turn"}, 8'(turnIndicator), 8'd1);
    endtask

    initial begin
        int base;
        int seen;
        reset       = 1'b0;
        start       = 1'b0;
        ready       = 1'b0;
        command     = NONE;
        playerTotal = 5'd0;
        dealerTotal = 5'd0;
        dealDone    = 1'b0;
        tick();
        tick();
        check("rst_turn", 8'(turnIndicator), 8'd0);
        check("rst_req", 8'(dealReq), 8'd0);
        check("rst_tgt", 8'(dealTarget), 8'd0);
        check("rst_done", 8'(roundDone), 8'd0);
        check("rst_result", 8'(result), 8'd0);

        reset = 1'b1;
        tick();
        dealDone = 1'b1;
        tick();
        dealDone = 1'b0;
        tick();
        tick();
        check("idle_no_req", 8'(dealReq), 8'd0);
        check("idle_no_turn", 8'(turnIndicator), 8'd0);

        // Round 1: deal order, then a HIT that busts the player.
        start_round("r1", 5'd5, 5'd10, 5'd12, 5'd20);
        base = dealer_rises;
        press(HIT);
        check("r1_turn_off", 8'(turnIndicator), 8'd0);
        serve_deal("r1_hit", 1'b0, 5'd22, 5'd20);
        tick();
        tick();
        check("r1_result", 8'(result), 8'd2);
        check("r1_done", 8'(roundDone), 8'd1);
        check("r1_no_dealer", 8'(dealer_rises - base), 8'd0);

        // Round 2: start ignored mid-turn; dealer draws 12 -> 16 -> 19 against 18.
        start_round("r2", 5'd9, 5'd6, 5'd18, 5'd12);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_start_ign_turn", 8'(turnIndicator), 8'd1);
        check("r2_start_ign_req", 8'(dealReq), 8'd0);
        base = dealer_rises;
        press(STAND);
        serve_deal("r2_dd1", 1'b1, 5'd18, 5'd16);
        serve_deal("r2_dd2", 1'b1, 5'd18, 5'd19);
        tick();
        tick();
        check("r2_result", 8'(result), 8'd2);
        check("r2_done", 8'(roundDone), 8'd1);
        tick();
        tick();
        check("r2_dealer_cnt", 8'(dealer_rises - base), 8'd2);

        // Round 3: held HIT acts once; NONE ignored; push at 20/20.
        start_round("r3", 5'd5, 5'd10, 5'd10, 5'd20);
        base = player_rises;
        seen = 0;
        ready   = 1'b1;
        command = HIT;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dealReq) seen++;
        end
        check("r3_hold_no_req", 8'(seen), 8'd0);
        check("r3_hold_turn", 8'(turnIndicator), 8'd0);
        ready   = 1'b0;
        command = NONE;
        serve_deal("r3_hit1", 1'b0, 5'd15, 5'd20);
        tick();
        check("r3_one_req", 8'(player_rises - base), 8'd1);
        check("r3_turn_back", 8'(turnIndicator), 8'd1);
        press(HIT);
        serve_deal("r3_hit2", 1'b0, 5'd20, 5'd20);
        tick();
        check("r3_second_hit", 8'(player_rises - base), 8'd2);
        ready   = 1'b1;
        command = NONE;
        tick();
        tick();
        tick();
        ready = 1'b0;
        check("r3_none_turn", 8'(turnIndicator), 8'd1);
        check("r3_none_req", 8'(dealReq), 8'd0);
        press(STAND);
        tick();
        tick();
        check("r3_push", 8'(result), 8'd3);

        // Round 4: dealer busts with 23 against 15; result holds in DONE.
        start_round("r4", 5'd5, 5'd8, 5'd15, 5'd16);
        press(STAND);
        serve_deal("r4_dd", 1'b1, 5'd15, 5'd23);
        tick();
        tick();
        check("r4_result", 8'(result), 8'd1);
        tick();
        tick();
        tick();
        check("r4_hold_result", 8'(result), 8'd1);
        check("r4_hold_done", 8'(roundDone), 8'd1);

        // Asynchronous reset while the dealer card of the first pair is requested.
        start = 1'b1;
        tick();
        start = 1'b0;
        serve_deal("r5_d1", 1'b0, 5'd7, 5'd0);
        wait_req("r5_d2");
        check("r5_pre_tgt", 8'(dealTarget), 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check("r5_rst_req", 8'(dealReq), 8'd0);
        check("r5_rst_tgt", 8'(dealTarget), 8'd0);
        check("r5_rst_turn", 8'(turnIndicator), 8'd0);
        check("r5_rst_done", 8'(roundDone), 8'd0);
        check("r5_rst_result", 8'(result), 8'd0);
        tick();
        reset = 1'b1;
        tick();
        base = player_rises + dealer_rises;
        dealDone = 1'b1;
        tick();
        dealDone = 1'b0;
        tick();
        tick();
        check("r5_idle_req", 8'(dealReq), 8'd0);
        check("r5_idle_cnt", 8'(player_rises + dealer_rises - base), 8'd0);

        start_round("r6", 5'd4, 5'd9, 5'd11, 5'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter DEALER_STAND, default 17: dealer draws while dealerTotal < DEALER_STAND.
REQ-002 SHALL have parameter BUST_LIMIT, default 21: a total > BUST_LIMIT is a bust.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a round; honoured only in IDLE or DONE.
REQ-006 SHALL have port ready, input, 1: player pressed a button during their turn.
REQ-007 SHALL have port command, input, gameCommand (2 bits: NONE=0, HIT=1, STAND=2): player choice.
REQ-008 SHALL have port playerTotal, input, 5: current player hand value.
REQ-009 SHALL have port dealerTotal, input, 5: current dealer hand value.
REQ-010 SHALL have port dealDone, input, 1: one-cycle acknowledge that the requested card was dealt.
REQ-011 SHALL have port turnIndicator, output, 1: high only in PLAYER_WAIT.
REQ-012 SHALL have port dealReq, output, 1: request one card from the dealer datapath.
REQ-013 SHALL have port dealTarget, output, 1: 0 = player hand, 1 = dealer hand; valid while dealReq is high.
REQ-014 SHALL have port roundDone, output, 1: high while in DONE.
REQ-015 SHALL have port result, output, 2: 0 = none, 1 = player wins, 2 = dealer wins, 3 = push.

Function
REQ-016 SHALL implement these states: IDLE, INIT_DEAL, PLAYER_WAIT, PLAYER_RELEASE, PLAYER_DEAL, PLAYER_CHECK, DEALER_CHECK, DEALER_DEAL, RESOLVE, DONE.
REQ-017 SHALL in IDLE or DONE with start=1 clear result to 0 and enter INIT_DEAL next cycle.
REQ-018 SHALL in INIT_DEAL issue exactly 4 deals in order player, dealer, player, dealer, tracked by a 2-bit counter, then enter PLAYER_CHECK.
REQ-019 SHALL hold dealReq high with dealTarget stable from the cycle after state entry until the cycle dealDone=1; dealReq SHALL deassert the cycle after dealDone.
REQ-020 SHALL ignore dealDone while dealReq=0.
REQ-021 SHALL sample totals no earlier than one cycle after dealDone.
REQ-022 SHALL in PLAYER_CHECK enter RESOLVE if playerTotal > BUST_LIMIT, else PLAYER_WAIT.
REQ-023 SHALL in PLAYER_WAIT with ready=1 and command=HIT enter PLAYER_RELEASE, then PLAYER_DEAL (target 0), then PLAYER_CHECK.
REQ-024 SHALL in PLAYER_WAIT with ready=1 and command=STAND enter PLAYER_RELEASE, then DEALER_CHECK.
REQ-025 SHALL remain in PLAYER_RELEASE until ready=0, so that one press yields exactly one action.
REQ-026 SHALL ignore ready=1 with command=NONE.
REQ-027 SHALL in DEALER_CHECK enter DEALER_DEAL (target 1) if dealerTotal < DEALER_STAND, else RESOLVE; DEALER_DEAL SHALL return to DEALER_CHECK after dealDone.
REQ-028 SHALL in RESOLVE set result as follows, then enter DONE one cycle later:
- player bust: 2
- dealer bust: 1
- higher total wins: 1 or 2
- equal totals: 3
REQ-029 SHALL hold result stable from DONE until the next accepted start.
REQ-030 SHALL ignore start in all states other than IDLE and DONE.
REQ-031 SHALL compare totals unsigned, 5 bits wide.

Reset
REQ-032 SHALL on reset=0, at any time including mid-deal, immediately enter IDLE and drive turnIndicator=0, dealReq=0, dealTarget=0, roundDone=0, result=0.
REQ-033 SHALL, after reset deasserts, take no action until start=1.

Verification
REQ-034 Deal sequence: start pulse, dealDone one cycle after each dealReq -> four requests with dealTarget 0,1,0,1, then turnIndicator=1.
REQ-035 Player bust: playerTotal=22 after a HIT deal -> result=2, roundDone=1, with no dealer deals issued.
REQ-036 Dealer draws: STAND with dealerTotal=12, then 16, then 19; playerTotal=18 -> exactly two dealer deals, then result=2.
REQ-037 Button held: ready=1 with HIT held for 10 cycles -> exactly one dealReq; a second HIT is accepted only after ready=0.
REQ-038 Push and dealer bust: totals 20/20 -> result=3; dealerTotal=23 with playerTotal=15 -> result=1.
REQ-039 Reset mid-deal: reset=0 while dealReq=1 -> all outputs 0 immediately; a later dealDone while in IDLE is ignored.
